// File: rtl/btb_predictor_if.sv
// Fetch lookup, branch resolution, flush and perf bundle for the BTB.
// The master side drives requests; the slave side is the predictor.
interface btb_predictor_if;
    logic [31:0] fetch_pc;
    logic        btb_hit;
    logic        predicted_outcome;
    logic [31:0] predicted_target;
    logic        update_btb;
    logic [31:0] update_pc;
    logic        branch_outcome;
    logic [31:0] branch_target;
    logic        misprediction;
    logic        flush_req;
    logic        flush_busy;
    logic [31:0] perf_updates;
    logic [31:0] perf_mispredicts;

    modport master (
        output fetch_pc, update_btb, update_pc, branch_outcome,
        output branch_target, misprediction, flush_req,
        input  btb_hit, predicted_outcome, predicted_target,
        input  flush_busy, perf_updates, perf_mispredicts
    );

    modport slave (
        input  fetch_pc, update_btb, update_pc, branch_outcome,
        input  branch_target, misprediction, flush_req,
        output btb_hit, predicted_outcome, predicted_target,
        output flush_busy, perf_updates, perf_mispredicts
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, a one-entry-per-cycle
// invalidate sequencer and saturating perf counters.
module btb_predictor #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic           CLK,
    input  logic           RST,
    btb_predictor_if.slave bus
);
    localparam int IDX_BITS = $clog2(NUM_ENTRIES);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ENTRIES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                 state;
    logic                   busy;
    logic [IDX_BITS-1:0]    flush_idx;
    logic [NUM_ENTRIES-1:0] valid;
    logic [1:0]             ctr     [NUM_ENTRIES];
    logic [TAG_BITS-1:0]    tags    [NUM_ENTRIES];
    logic [31:0]            targets [NUM_ENTRIES];
    logic [31:0]            n_upd;
    logic [31:0]            n_mis;

    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                f_hit;
    logic                u_hit;
    logic                unused_pc_bits;

    assign f_idx = bus.fetch_pc[IDX_BITS+1:2];
    assign f_tag = bus.fetch_pc[31:IDX_BITS+2];
    assign u_idx = bus.update_pc[IDX_BITS+1:2];
    assign u_tag = bus.update_pc[31:IDX_BITS+2];
    assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

    // Table contents are stale while flushing, so the lookup is masked.
    assign f_hit = !busy && valid[f_idx] && (tags[f_idx] == f_tag);
    assign u_hit = valid[u_idx] && (tags[u_idx] == u_tag);

    assign bus.btb_hit           = f_hit;
    assign bus.predicted_outcome = f_hit && ctr[f_idx][1];
    assign bus.predicted_target  = (f_hit && ctr[f_idx][1]) ?
                                   targets[f_idx] : bus.fetch_pc + 32'd4;
    assign bus.flush_busy        = busy;
    assign bus.perf_updates      = n_upd;
    assign bus.perf_mispredicts  = n_mis;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            flush_idx <= '0;
            valid     <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ctr[i]     <= 2'b01;
                tags[i]    <= '0;
                targets[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        state     <= FLUSH;
                        busy      <= 1'b1;
                        flush_idx <= '0;
                    end else if (bus.update_btb) begin
                        if (u_hit) begin
                            if (bus.branch_outcome) begin
                                if (ctr[u_idx] != 2'b11)
                                    ctr[u_idx] <= ctr[u_idx] + 2'b01;
                                targets[u_idx] <= bus.branch_target;
                            end else if (ctr[u_idx] != 2'b00) begin
                                ctr[u_idx] <= ctr[u_idx] - 2'b01;
                            end
                        end else if (bus.branch_outcome) begin
                            valid[u_idx]   <= 1'b1;
                            tags[u_idx]    <= u_tag;
                            targets[u_idx] <= bus.branch_target;
                            ctr[u_idx]     <= 2'b10;
                        end
                    end
                end
                FLUSH: begin
                    valid[flush_idx] <= 1'b0;
                    ctr[flush_idx]   <= 2'b01;
                    flush_idx        <= flush_idx + 1'b1;
                    if (flush_idx == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            n_upd <= '0;
            n_mis <= '0;
        end else if (bus.update_btb) begin
            if (n_upd != 32'hFFFF_FFFF)
                n_upd <= n_upd + 32'd1;
            if (bus.misprediction && n_mis != 32'hFFFF_FFFF)
                n_mis <= n_mis + 32'd1;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: lookup, counters, aliasing,
// flush sequencing, perf counting and reset abort.
module tb_btb_predictor;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;
    int   n;

    btb_predictor_if bus ();

    btb_predictor #(.NUM_ENTRIES(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic mis);
        bus.update_btb     = 1'b1;
        bus.update_pc      = pc;
        bus.branch_outcome = taken;
        bus.branch_target  = tgt;
        bus.misprediction  = mis;
        step();
        bus.update_btb     = 1'b0;
        bus.misprediction  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic out,
                        input logic [31:0] tgt);
        bus.fetch_pc = pc;
        #1;
        check({tag, "_hit"}, 32'(bus.btb_hit), 32'(hit));
        check({tag, "_out"}, 32'(bus.predicted_outcome), 32'(out));
        check({tag, "_tgt"}, bus.predicted_target, tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST = 1'b1;
        bus.fetch_pc       = 32'h100;
        bus.update_btb     = 1'b0;
        bus.update_pc      = '0;
        bus.branch_outcome = 1'b0;
        bus.branch_target  = '0;
        bus.misprediction  = 1'b0;
        bus.flush_req      = 1'b0;
        #1;
        look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
        check("rst_upd", bus.perf_updates, 32'd0);
        check("rst_mis", bus.perf_mispredicts, 32'd0);
        check("rst_busy", 32'(bus.flush_busy), 32'd0);
        step();
        step();
        RST = 1'b0;
        step();

        upd(32'h100, 1'b1, 32'h140, 1'b0);
        look("t2a", 32'h100, 1'b1, 1'b1, 32'h140);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("t2b", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("t2c", 32'h100, 1'b1, 1'b0, 32'h104);
        check("t2_upd", bus.perf_updates, 32'd3);

        upd(32'h200, 1'b1, 32'h280, 1'b0);
        upd(32'h200, 1'b1, 32'h280, 1'b0);
        upd(32'h200, 1'b1, 32'h280, 1'b0);
        upd(32'h200, 1'b0, 32'h0, 1'b0);
        look("t3", 32'h200, 1'b1, 1'b1, 32'h280);
        upd(32'h200, 1'b0, 32'h0, 1'b0);
        look("t3b", 32'h200, 1'b1, 1'b0, 32'h204);
        look("t3ev", 32'h100, 1'b0, 1'b0, 32'h104);
        check("t3_upd", bus.perf_updates, 32'd8);

        upd(32'h100, 1'b1, 32'h180, 1'b0);
        upd(32'h140, 1'b1, 32'h1c0, 1'b0);
        look("t4a", 32'h100, 1'b0, 1'b0, 32'h104);
        look("t4b", 32'h140, 1'b1, 1'b1, 32'h1c0);
        upd(32'h140, 1'b0, 32'h0, 1'b0);
        look("t4c", 32'h140, 1'b1, 1'b0, 32'h144);

        upd(32'h104, 1'b1, 32'h500, 1'b0);
        upd(32'h108, 1'b1, 32'h600, 1'b0);
        upd(32'h10c, 1'b1, 32'h700, 1'b0);
        look("t5fill", 32'h108, 1'b1, 1'b1, 32'h600);
        check("t5_upd", bus.perf_updates, 32'd14);
        bus.flush_req = 1'b1;
        upd(32'h110, 1'b1, 32'h800, 1'b0);
        bus.flush_req = 1'b0;
        check("t5_busy", 32'(bus.flush_busy), 32'd1);
        n = 0;
        while (bus.flush_busy && n < 40) begin
            n++;
            if (n == 2) begin
                bus.update_btb     = 1'b1;
                bus.update_pc      = 32'h114;
                bus.branch_outcome = 1'b1;
                bus.branch_target  = 32'h900;
            end
            if (n == 5)
                bus.flush_req = 1'b1;
            if (n == 3)
                look("t5mid", 32'h108, 1'b0, 1'b0, 32'h10c);
            step();
            bus.update_btb = 1'b0;
            bus.flush_req  = 1'b0;
        end
        check("t5_cycles", 32'(n), 32'd16);
        look("t5p104", 32'h104, 1'b0, 1'b0, 32'h108);
        look("t5p108", 32'h108, 1'b0, 1'b0, 32'h10c);
        look("t5p10c", 32'h10c, 1'b0, 1'b0, 32'h110);
        look("t5p110", 32'h110, 1'b0, 1'b0, 32'h114);
        look("t5p114", 32'h114, 1'b0, 1'b0, 32'h118);
        look("t5p140", 32'h140, 1'b0, 1'b0, 32'h144);
        check("t5_upd2", bus.perf_updates, 32'd16);

        bus.fetch_pc       = 32'h300;
        bus.update_btb     = 1'b1;
        bus.update_pc      = 32'h300;
        bus.branch_outcome = 1'b1;
        bus.branch_target  = 32'h340;
        bus.misprediction  = 1'b1;
        #1;
        check("t6_same", 32'(bus.btb_hit), 32'd0);
        step();
        bus.update_btb    = 1'b0;
        bus.misprediction = 1'b0;
        look("t6_next", 32'h300, 1'b1, 1'b1, 32'h340);
        check("t6_mis", bus.perf_mispredicts, 32'd1);
        check("t6_upd", bus.perf_updates, 32'd17);

        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        step();
        step();
        check("t6_busy", 32'(bus.flush_busy), 32'd1);
        RST = 1'b1;
        #1;
        check("t6_rbusy", 32'(bus.flush_busy), 32'd0);
        look("t6_rlook", 32'h300, 1'b0, 1'b0, 32'h304);
        check("t6_rupd", bus.perf_updates, 32'd0);
        step();
        RST = 1'b0;
        step();
        step();
        check("t6_idle", 32'(bus.flush_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
